keypad_time_entry: RTL and testbench
====================================

// Module: keypad_time_entry
// PURPOSE
//   Keypad front end of the microwave cook-time path. Turns key presses into an
//   M:SS entry: digits shift in from the right, as on a microwave keypad.
//   On START it validates the entry, drives the BCD digits and a Load strobe into
//   the minutes/seconds countdown timer, then issues a start request to the
//   controller. Sits directly upstream of the timer; the timer's initial_* and
//   Load inputs connect straight to this block's outputs.
// PARAMETERS
//   LOAD_CYCLES  1     cycles Load is held high per accepted START (1..15)
//   KEY_CANCEL   4'hA  key_code meaning cancel/clear entry
//   KEY_START    4'hB  key_code meaning start cooking
// PORTS
//   CLK                    in   1  system clock, rising edge
//   Clear                  in   1  asynchronous reset, active-high
//   key_valid              in   1  level; high while a key is held
//   key_code               in   4  key id: 0-9 digit, KEY_CANCEL, KEY_START, others ignored
//   entry_seconds_units    out  4  BCD seconds units -> timer initial_seconds_units
//   entry_seconds_tens     out  3  seconds tens (0-5) -> timer initial_seconds_tens
//   entry_minutes_units    out  4  BCD minutes units -> timer initial_minutes_units
//   Load                   out  1  load strobe to timer
//   start_req              out  1  one-cycle pulse: timer loaded, controller may enable
//   entry_error            out  1  one-cycle pulse: START rejected
//   digit_count            out  2  digits entered so far (0-3)
// BEHAVIOUR
//   Reset: Clear=1 forces, asynchronously, all digits=0, digit_count=0, Load=0,
//     start_req=0, entry_error=0, key_valid_q=0, state=IDLE. Clear dominates
//     everything, including an in-progress LOAD.
//   Key event: on a rising CLK edge where key_valid=1 and key_valid_q=0, key_code
//     is sampled in the same edge. key_valid_q <= key_valid every cycle.
//     A held key gives exactly one event. Outputs update on that edge
//     (1-cycle latency).
//   Digit storage: internal su, st, mu are 4 bits each. entry_seconds_tens = st[2:0].
//   FSM states: IDLE, ENTRY, LOAD.
//   IDLE
//     digit d -> su=d, st=0, mu=0, count=1, go to ENTRY. A fresh entry starts
//       here, so the previous load's digits are discarded.
//     START   -> entry_error pulse; stay in IDLE.
//     CANCEL  -> digits=0.
//   ENTRY
//     digit d with count<3 -> mu<=st, st<=su, su<=d, count+1.
//     digit with count=3   -> ignored. No change, no error.
//     CANCEL -> digits=0, count=0, go to IDLE.
//     START, valid -> go to LOAD. Load=1 from the next cycle for LOAD_CYCLES cycles.
//     START, invalid -> entry_error pulse (next cycle). State and digits are kept.
//       Invalid means st>5, or the entry is all zero (0:00).
//   LOAD
//     Load is held for LOAD_CYCLES cycles, with the digits held stable.
//     Key events during LOAD are discarded, including CANCEL.
//     In the cycle after Load falls: start_req=1 for 1 cycle, count=0, go to IDLE.
//     Digits stay on the outputs until the next digit or CANCEL.
//   Events that coincide: one event per edge, by construction.
//     Clear asserted mid-LOAD -> Load drops immediately and no start_req is issued.
//   Load and start_req are never high in the same cycle.
//     entry_error is never high in LOAD.
// TESTING
//   1. Keys 8,5,7 then START (LOAD_CYCLES=1) -> mu=8, st=5, su=7, count=3.
//      Load high 1 cycle, then start_req high 1 cycle, then count=0.
//   2. Keys 1,9,0 then START -> entry_error pulse, no Load.
//      Outputs stay 1:90 (st=9 truncates to entry_seconds_tens=3'b001). State stays ENTRY.
//   3. Keys 4,2,3,6 -> fourth digit ignored: mu=4, st=2, su=3.
//      START -> Load, then start_req.
//   4. key_valid held 20 cycles with key_code=5 -> exactly one shift, su=5, count=1.
//   5. Keys 3,0, CANCEL, then START -> digits 0, count 0, entry_error pulse.
//      Also: keys 0,0,START -> entry_error (0:00 rejected).
//   6. LOAD_CYCLES=4, accepted START, Clear pulsed in the 2nd Load cycle ->
//      Load=0 and all outputs 0 immediately, no start_req. Digit 7 after release -> su=7.

Source files
------------

// File: rtl/keypad_time_entry.sv
// Keypad front end for the microwave cook-time path.
// Shifts digits into an M:SS entry, validates on START and loads the timer.
module keypad_time_entry #(
  parameter int unsigned LOAD_CYCLES = 1,
  parameter logic [3:0]  KEY_CANCEL  = 4'hA,
  parameter logic [3:0]  KEY_START   = 4'hB
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] entry_seconds_units,
  output logic [2:0] entry_seconds_tens,
  output logic [3:0] entry_minutes_units,
  output logic       Load,
  output logic       start_req,
  output logic       entry_error,
  output logic [1:0] digit_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  state_e     state_q, state_d;
  logic       key_valid_q;
  logic [3:0] su_q, su_d;
  logic [3:0] st_q, st_d;
  logic [3:0] mu_q, mu_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] load_cnt_q, load_cnt_d;
  logic       load_q, load_d;
  logic       start_q, start_d;
  logic       err_q, err_d;

  logic key_ev;
  logic is_digit;
  logic is_cancel;
  logic is_start;
  logic entry_ok;

  // One event per press: rising edge of the held-key level.
  assign key_ev    = key_valid & ~key_valid_q;
  assign is_digit  = (key_code <= 4'd9);
  assign is_cancel = (key_code == KEY_CANCEL);
  assign is_start  = (key_code == KEY_START);
  assign entry_ok  = (st_q <= 4'd5) &&
                     ({mu_q, st_q, su_q} != 12'd0);

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      su_q        <= '0;
      st_q        <= '0;
      mu_q        <= '0;
      cnt_q       <= '0;
      load_cnt_q  <= '0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid;
      su_q        <= su_d;
      st_q        <= st_d;
      mu_q        <= mu_d;
      cnt_q       <= cnt_d;
      load_cnt_q  <= load_cnt_d;
      load_q      <= load_d;
      start_q     <= start_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (key_ev && is_digit)
          state_d = ENTRY;
      end
      ENTRY: begin
        if (key_ev && is_cancel)
          state_d = IDLE;
        else if (key_ev && is_start && entry_ok)
          state_d = LOAD;
      end
      LOAD: begin
        if (load_cnt_q == 4'd0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    su_d       = su_q;
    st_d       = st_q;
    mu_d       = mu_q;
    cnt_d      = cnt_q;
    load_cnt_d = load_cnt_q;
    load_d     = 1'b0;
    start_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_ev) begin
          unique case (1'b1)
            is_digit: begin
              su_d  = key_code;
              st_d  = '0;
              mu_d  = '0;
              cnt_d = 2'd1;
            end
            is_start: err_d = 1'b1;
            is_cancel: begin
              su_d = '0;
              st_d = '0;
              mu_d = '0;
            end
            default: ;
          endcase
        end
      end
      ENTRY: begin
        if (key_ev) begin
          unique case (1'b1)
            is_digit: begin
              if (cnt_q != 2'd3) begin
                mu_d  = st_q;
                st_d  = su_q;
                su_d  = key_code;
                cnt_d = cnt_q + 2'd1;
              end
            end
            is_cancel: begin
              su_d  = '0;
              st_d  = '0;
              mu_d  = '0;
              cnt_d = '0;
            end
            is_start: begin
              if (entry_ok) begin
                load_d     = 1'b1;
                load_cnt_d = LOAD_LAST;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        // Keys are ignored here; digits stay stable under Load.
        if (load_cnt_q != 4'd0) begin
          load_d     = 1'b1;
          load_cnt_d = load_cnt_q - 4'd1;
        end else begin
          start_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign entry_seconds_units = su_q;
  assign entry_seconds_tens  = st_q[2:0];
  assign entry_minutes_units = mu_q;
  assign Load                = load_q;
  assign start_req           = start_q;
  assign entry_error         = err_q;
  assign digit_count         = cnt_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed bench for keypad_time_entry.
// Second instance exercises a 4-cycle Load with Clear mid-load.
module tb_keypad_time_entry;

  logic       clk = 1'b0;
  logic       clr;
  logic       kv;
  logic [3:0] kc;

  logic [3:0] su1, mu1, su4, mu4;
  logic [2:0] st1, st4;
  logic       ld1, sr1, er1, ld4, sr4, er4;
  logic [1:0] dc1, dc4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  keypad_time_entry #(.LOAD_CYCLES(1)) dut (
    .CLK(clk), .Clear(clr),
    .key_valid(kv), .key_code(kc),
    .entry_seconds_units(su1),
    .entry_seconds_tens(st1),
    .entry_minutes_units(mu1),
    .Load(ld1), .start_req(sr1),
    .entry_error(er1), .digit_count(dc1)
  );

  keypad_time_entry #(.LOAD_CYCLES(4)) dut4 (
    .CLK(clk), .Clear(clr),
    .key_valid(kv), .key_code(kc),
    .entry_seconds_units(su4),
    .entry_seconds_tens(st4),
    .entry_minutes_units(mu4),
    .Load(ld4), .start_req(sr4),
    .entry_error(er4), .digit_count(dc4)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  // Inputs change on the falling edge; one rising edge sees the key.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    kv = 1'b1;
    kc = c;
    @(negedge clk);
    kv = 1'b0;
  endtask

  task automatic chk1(input string tag,
                      input logic [3:0] m,
                      input logic [2:0] s,
                      input logic [3:0] u,
                      input logic [1:0] c);
    check({tag, ".mu"}, 32'(mu1), 32'(m));
    check({tag, ".st"}, 32'(st1), 32'(s));
    check({tag, ".su"}, 32'(su1), 32'(u));
    check({tag, ".cnt"}, 32'(dc1), 32'(c));
  endtask

  logic seen_sr;

  initial begin
    clr = 1'b1;
    kv  = 1'b0;
    kc  = 4'h0;
    #12;
    chk1("rst", 4'd0, 3'd0, 4'd0, 2'd0);
    check("rst.load", 32'(ld1), 32'd0);
    check("rst.sreq", 32'(sr1), 32'd0);
    check("rst.err", 32'(er1), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // 1: 8:57 accepted
    press(4'd8);
    chk1("t1a", 4'd0, 3'd0, 4'd8, 2'd1);
    press(4'd5);
    chk1("t1b", 4'd0, 3'd0, 4'd5, 2'd2);
    press(4'd7);
    chk1("t1c", 4'd8, 3'd5, 4'd7, 2'd3);
    press(4'hB);
    check("t1.load", 32'(ld1), 32'd1);
    check("t1.sreq0", 32'(sr1), 32'd0);
    check("t1.err", 32'(er1), 32'd0);
    @(negedge clk);
    check("t1.load_off", 32'(ld1), 32'd0);
    check("t1.sreq", 32'(sr1), 32'd1);
    chk1("t1d", 4'd8, 3'd5, 4'd7, 2'd0);
    @(negedge clk);
    check("t1.sreq_off", 32'(sr1), 32'd0);

    // 2: 1:90 rejected, stays in ENTRY
    press(4'd1);
    press(4'd9);
    press(4'd0);
    chk1("t2a", 4'd1, 3'd1, 4'd0, 2'd3);
    press(4'hB);
    check("t2.err", 32'(er1), 32'd1);
    check("t2.load", 32'(ld1), 32'd0);
    @(negedge clk);
    check("t2.err_off", 32'(er1), 32'd0);
    check("t2.load2", 32'(ld1), 32'd0);
    check("t2.sreq", 32'(sr1), 32'd0);
    chk1("t2b", 4'd1, 3'd1, 4'd0, 2'd3);
    press(4'hA);
    chk1("t2c", 4'd0, 3'd0, 4'd0, 2'd0);

    // 3: fourth digit ignored
    press(4'd4);
    press(4'd2);
    press(4'd3);
    press(4'd6);
    chk1("t3a", 4'd4, 3'd2, 4'd3, 2'd3);
    check("t3.err", 32'(er1), 32'd0);
    press(4'hB);
    check("t3.load", 32'(ld1), 32'd1);
    @(negedge clk);
    check("t3.sreq", 32'(sr1), 32'd1);
    check("t3.load_off", 32'(ld1), 32'd0);

    // 4: held key gives one event
    @(negedge clk);
    kv = 1'b1;
    kc = 4'd5;
    repeat (20) @(negedge clk);
    kv = 1'b0;
    chk1("t4", 4'd0, 3'd0, 4'd5, 2'd1);

    // 5: cancel then START, and 0:00
    press(4'hA);
    press(4'd3);
    press(4'd0);
    chk1("t5a", 4'd0, 3'd3, 4'd0, 2'd2);
    press(4'hA);
    chk1("t5b", 4'd0, 3'd0, 4'd0, 2'd0);
    press(4'hB);
    check("t5.err", 32'(er1), 32'd1);
    check("t5.load", 32'(ld1), 32'd0);
    @(negedge clk);
    check("t5.err_off", 32'(er1), 32'd0);
    press(4'd0);
    press(4'd0);
    press(4'hB);
    check("t5.zero_err", 32'(er1), 32'd1);
    check("t5.zero_load", 32'(ld1), 32'd0);
    chk1("t5c", 4'd0, 3'd0, 4'd0, 2'd2);

    // 6: Clear in the 2nd Load cycle of a 4-cycle load
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    press(4'd1);
    press(4'd3);
    press(4'd0);
    press(4'hB);
    check("t6.load1", 32'(ld4), 32'd1);
    @(negedge clk);
    check("t6.load2", 32'(ld4), 32'd1);
    check("t6.su_hold", 32'(su4), 32'd0);
    check("t6.st_hold", 32'(st4), 32'd3);
    clr = 1'b1;
    #1;
    check("t6.load_clr", 32'(ld4), 32'd0);
    check("t6.mu_clr", 32'(mu4), 32'd0);
    check("t6.st_clr", 32'(st4), 32'd0);
    check("t6.cnt_clr", 32'(dc4), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    seen_sr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (sr4 || er4) seen_sr = 1'b1;
    end
    check("t6.no_sreq", 32'(seen_sr), 32'd0);
    press(4'd7);
    check("t6.su7", 32'(su4), 32'd7);
    check("t6.cnt1", 32'(dc4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Load and start_req must never overlap; no error while loading.
  always @(negedge clk) begin
    if (!clr && ((ld1 && sr1) || (ld4 && sr4))) begin
      check("overlap", 32'd1, 32'd0);
    end
    if (!clr && ((ld1 && er1) || (ld4 && er4))) begin
      check("err_in_load", 32'd1, 32'd0);
    end
  end

endmodule
